// File: rtl/regfile_pkg.sv
// Shared constants and port bundle types for the multi-port integer register file.
package regfile_pkg;

  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int ZERO_IDX       = 0;

  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0] addr;
  } rd_port_t;

  typedef struct packed {
    logic                      en;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] data;
  } wr_port_t;

endpackage

// File: rtl/regfile_wprio.sv
// Write-port priority resolver: reports whether any enabled write port targets
// a given index and which port wins (highest port number).
module regfile_wprio #(
  parameter int ADDR_WIDTH = 5,
  parameter int NW         = 1,
  parameter int SW         = (NW > 1) ? $clog2(NW) : 1
) (
  input  logic [NW-1:0]            wen,
  input  logic [NW*ADDR_WIDTH-1:0] waddr,
  input  logic [ADDR_WIDTH-1:0]    target,
  output logic                     hit,
  output logic [SW-1:0]            sel
);

  always_comb begin
    // NOTE: defaults first so every path assigns hit/sel and no latch is inferred.
    hit = 1'b0;
    sel = '0;
    // NOTE: blocking assignments in combinational logic; a later (higher) port
    // overwrites an earlier match, which is exactly the priority we want.
    for (int j = 0; j < NW; j++) begin
      if (wen[j] && (waddr[j*ADDR_WIDTH +: ADDR_WIDTH] == target)) begin
        hit = 1'b1;
        sel = SW'(j);
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write priority, optional bypass, hardwired zero
// register, pending-write scoreboard and a registered change report.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64,
  parameter int NR         = 2,
  parameter int NW         = 1,
  parameter bit BYPASS     = 1'b1,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NR*ADDR_WIDTH-1:0] raddr,
  output logic [NR*DATA_WIDTH-1:0] rdata,
  output logic [NR-1:0]            rpend,
  input  logic [NW-1:0]            wen,
  input  logic [NW*ADDR_WIDTH-1:0] waddr,
  input  logic [NW*DATA_WIDTH-1:0] wdata,
  input  logic                     alloc_en,
  input  logic [ADDR_WIDTH-1:0]    alloc_rd,
  output logic                     dbg_chg,
  output logic [ADDR_WIDTH-1:0]    dbg_idx,
  output logic [DATA_WIDTH-1:0]    dbg_old,
  output logic [DATA_WIDTH-1:0]    dbg_new
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);
  localparam int SW    = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_IDX);

  logic [DATA_WIDTH-1:0] rf     [DEPTH];
  logic [DATA_WIDTH-1:0] wr_val [DEPTH];
  logic [DEPTH-1:0]      pend;
  logic [DEPTH-1:0]      wr_hit;
  logic [DEPTH-1:0]      wr_ok;
  logic [DEPTH-1:0]      alloc_hit;

  logic                  chg_c;
  logic [ADDR_WIDTH-1:0] idx_c;
  logic [DATA_WIDTH-1:0] old_c;
  logic [DATA_WIDTH-1:0] new_c;

  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    logic [SW-1:0] sel;

    regfile_wprio #(.ADDR_WIDTH(ADDR_WIDTH), .NW(NW), .SW(SW)) u_wprio (
      .wen    (wen),
      .waddr  (waddr),
      .target (ADDR_WIDTH'(i)),
      .hit    (wr_hit[i]),
      .sel    (sel)
    );

    assign wr_ok[i]     = wr_hit[i] && !(ZERO_REG && (i == ZERO_IDX));
    assign alloc_hit[i] = alloc_en && (alloc_rd == ADDR_WIDTH'(i)) && !(ZERO_REG && (i == ZERO_IDX));
    assign wr_val[i]    = wdata[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
  end

  // Descending scan so the lowest changed index is the one left standing.
  always_comb begin
    chg_c = 1'b0;
    idx_c = '0;
    old_c = '0;
    new_c = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (wr_ok[i] && (wr_val[i] != rf[i])) begin
        chg_c = 1'b1;
        idx_c = ADDR_WIDTH'(i);
        old_c = rf[i];
        new_c = wr_val[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the storage array is cleared on reset because the architecture
      // defines every register as zero after reset, so it is built from flops.
      for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
      pend    <= '0;
      dbg_chg <= 1'b0;
      dbg_idx <= '0;
      dbg_old <= '0;
      dbg_new <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_ok[i]) rf[i] <= wr_val[i];
        // A same-cycle allocation is younger than the completing write.
        if (alloc_hit[i])  pend[i] <= 1'b1;
        else if (wr_ok[i]) pend[i] <= 1'b0;
      end
      dbg_chg <= chg_c;
      dbg_idx <= idx_c;
      dbg_old <= old_c;
      dbg_new <= new_c;
    end
  end

  for (genvar k = 0; k < NR; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic                  is_zero;
    logic                  hit;
    logic [SW-1:0]         sel;

    assign ra      = raddr[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign is_zero = ZERO_REG && (ra == ZERO_ADDR);

    regfile_wprio #(.ADDR_WIDTH(ADDR_WIDTH), .NW(NW), .SW(SW)) u_wprio (
      .wen    (wen),
      .waddr  (waddr),
      .target (ra),
      .hit    (hit),
      .sel    (sel)
    );

    assign rdata[k*DATA_WIDTH +: DATA_WIDTH] =
      is_zero         ? '0 :
      (BYPASS && hit) ? wdata[int'(sel)*DATA_WIDTH +: DATA_WIDTH] :
                        rf[ra];
    assign rpend[k] = !is_zero && pend[ra];
  end

  // Same-index dual write is legal (higher port wins); flag it for visibility.
  if (NW == 2) begin : g_conflict
    wr_conflict_c: cover property (@(posedge clk) disable iff (rst)
      (wen == 2'b11) && (waddr[0 +: ADDR_WIDTH] == waddr[ADDR_WIDTH +: ADDR_WIDTH]));
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file for the LemonPC core and the next generation of the single-write, dual-read file. It provides NR combinational read ports, NW write ports with deterministic priority, optional write-to-read bypass, a hardwired zero register and synchronous clear. It also holds a per-register pending-write scoreboard that the issue stage uses to detect RAW hazards.

Parameters:
ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
DATA_WIDTH, 64, register width in bits
NR, 2, number of read ports (1..4)
NW, 1, number of write ports (1..2)
BYPASS, 1, 1 = a read of a register being written this cycle returns the write data; 0 = returns the stored value
ZERO_REG, 1, 1 = register 0 always reads 0 and is never written or marked pending

Ports:
clk  in  1  clock, all state updates on its rising edge
rst  in  1  synchronous active-high reset
raddr  in  NR*ADDR_WIDTH  read indices; port k uses slice [k*ADDR_WIDTH +: ADDR_WIDTH]
rdata  out  NR*DATA_WIDTH  read data per port, combinational
rpend  out  NR  scoreboard pending bit of each read index, combinational
wen  in  NW  write enable per write port
waddr  in  NW*ADDR_WIDTH  write indices
wdata  in  NW*DATA_WIDTH  write data
alloc_en  in  1  mark alloc_rd as pending (issue of an instruction with a destination)
alloc_rd  in  ADDR_WIDTH  destination being allocated
dbg_chg  out  1  registered: at least one register value changed at the last edge
dbg_idx  out  ADDR_WIDTH  registered: lowest index that changed at the last edge
dbg_old  out  DATA_WIDTH  registered: previous value of dbg_idx
dbg_new  out  DATA_WIDTH  registered: new value of dbg_idx

Behaviour:
- Reset (rst=1 at an edge): all registers go to 0, all pending bits clear, dbg_chg=0, dbg_idx=0, dbg_old=0, dbg_new=0. Reset overrides writes and alloc in the same cycle.
- Storage: DATA_WIDTH x 2**ADDR_WIDTH flops. The block contains no latches and no combinational assignment to the storage array.
- Write: at the edge, each port with wen[j]=1 and a valid target updates rf[waddr[j]]. Latency 1 cycle.
- Two ports writing the same index at the same edge: the higher port number wins. A single SVA assertion flags this case in simulation only; it is not an error in RTL.
- ZERO_REG=1: writes to index 0 are dropped; rdata for index 0 is 0; rpend for index 0 is 0; alloc_rd=0 is ignored.
- Read: rdata[k] = rf[raddr[k]] combinationally.
  - If BYPASS=1 and some wen[j] targets raddr[k] (nonzero when ZERO_REG=1), rdata[k] = wdata of the highest such j.
  - BYPASS does not affect rpend.
- Scoreboard, one bit per register, updated at the edge:
  - a write to index i clears pend[i];
  - alloc_en to index i sets pend[i];
  - both on the same i in the same cycle: set wins, because the new allocation is younger.
- rpend[k] reflects stored pend[raddr[k]], with no bypass of the same-cycle clear.
- Debug change report:
  - at each edge, compare pre- and post-write values of every written index;
  - dbg_chg=1 for exactly one cycle after the edge if any value differs;
  - dbg_idx, dbg_old and dbg_new describe the lowest-numbered changed register;
  - rewriting an equal value gives dbg_chg=0.
  - The debug path is synthesisable, not $display-based.
- rst asserted mid-stream clears everything at that edge; outputs valid from the next cycle.

Decomposition:
- Package regfile_pkg holds:
  - the localparam for DEPTH derivation;
  - a typedef for the packed read/write port bundle structs;
  - the ZERO_IDX constant.
- One sub-module is natural: regfile_wprio, which takes the NW enables and indices for a given target index and outputs the combinational "hit" and the winning port number. It is instantiated once per register for the storage write and once per read port for the bypass.

Test Plan:
- Reset then read all: rst=1 for one cycle, then raddr = 0..31 on both ports -> rdata=0 and rpend=0 everywhere.
- Write and bypass: wen[0]=1, waddr=5, wdata=0xDEAD_BEEF, raddr[0]=5. With BYPASS=1, rdata[0]=0xDEADBEEF in the same cycle. With BYPASS=0, rdata[0]=0 that cycle and 0xDEADBEEF the next.
- Zero register: write 0x1234 to index 0 and alloc_rd=0 -> rdata for index 0 = 0, rpend=0, dbg_chg=0.
- Dual-write conflict (NW=2): both ports write index 7 with 0x11 and 0x22 -> rf[7]=0x22; dbg_idx=7, dbg_old=0, dbg_new=0x22.
- Scoreboard:
  - alloc_rd=3 -> rpend for index 3 = 1 next cycle;
  - a write to 3 alone -> pend cleared next cycle;
  - a write to 3 plus alloc to 3 in the same cycle -> pend stays 1.
- Reset mid-operation: registers 1..4 written and pend[2]=1, then rst=1 for one cycle together with wen on index 9 -> all registers 0, pend all 0, rf[9]=0, dbg_chg=0.
